// File: rtl/tnn_neuron_serial.sv
// Serial ternary neuron: accumulates N_CH unsigned channels into a signed margin
// and emits (margin > THRESH). Optional port out_margin under TNN_NEURON_MARGIN_OUT_EN.
module tnn_neuron_serial #(
    parameter int              IN_W     = 3,
    parameter int              N_CH     = 6,
    parameter logic [N_CH-1:0] POS_MASK = 6'b000011,
    parameter int              THRESH   = 0,
    parameter int              ACC_W    = IN_W + $clog2(N_CH) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IN_W-1:0]         in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_bit,
`ifdef TNN_NEURON_MARGIN_OUT_EN
    output logic signed [ACC_W-1:0] out_margin,
`endif
    output logic                    busy
);

    generate
        if (N_CH < 2) begin : g_bad_n_ch
            $error("tnn_neuron_serial: N_CH must be at least 2");
        end
    endgenerate

    localparam int IDX_W  = $clog2(N_CH);
    localparam int MASK_W = 2 ** IDX_W;
    localparam logic [IDX_W-1:0]        LAST_IDX   = IDX_W'(N_CH - 1);
    localparam logic [MASK_W-1:0]       MASK_EXT   = MASK_W'(POS_MASK);
    localparam logic signed [ACC_W-1:0] THRESH_EXT = ACC_W'(THRESH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [1:0]              state;
    logic [IDX_W-1:0]        idx;
    logic signed [ACC_W-1:0] margin;
    logic signed [ACC_W-1:0] data_ext;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] next_margin;
    logic                    beat;

    assign in_ready = rst_n & (state != S_OUT);
    assign busy     = (state != S_IDLE);
    assign beat     = in_valid & in_ready;

    // In IDLE the accumulator starts from zero, so the first beat is a plain load.
    assign data_ext    = ACC_W'(in_data);
    assign term        = MASK_EXT[idx] ? data_ext : -data_ext;
    assign base        = (state == S_IDLE) ? '0 : margin;
    assign next_margin = base + term;

`ifdef TNN_NEURON_MARGIN_OUT_EN
    logic signed [ACC_W-1:0] margin_q;
    assign out_margin = margin_q;
`endif

    // clear takes priority over both an incoming beat and an output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            idx       <= '0;
            margin    <= '0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
`ifdef TNN_NEURON_MARGIN_OUT_EN
            margin_q  <= '0;
`endif
        end else if (clear) begin
            state     <= S_IDLE;
            idx       <= '0;
            margin    <= '0;
            out_valid <= 1'b0;
            out_bit   <= 1'b0;
`ifdef TNN_NEURON_MARGIN_OUT_EN
            margin_q  <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (beat) begin
                        margin <= next_margin;
                        idx    <= IDX_W'(1);
                        state  <= S_ACC;
                    end
                end
                S_ACC: begin
                    if (beat) begin
                        margin <= next_margin;
                        if (idx == LAST_IDX) begin
                            out_bit   <= (next_margin > THRESH_EXT);
                            out_valid <= 1'b1;
                            state     <= S_OUT;
`ifdef TNN_NEURON_MARGIN_OUT_EN
                            margin_q  <= next_margin;
`endif
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        idx       <= '0;
                        margin    <= '0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
